ifu_pc_gen: RTL and testbench
=============================

# ifu_pc_gen

Program-counter generation and next-fetch prediction for the instruction-fetch stage. Holds the fetch PC, drives the instruction ROM address, and predicts the next PC from the fetched word. JAL is predicted statically; conditional branches use a table of 2-bit counters trained from EX. Feeds pc, next_pc, next_taken and branch_slot_end into the IF/ID pipeline register, and accepts stall, flush and branch-redirect controls from CTRL and EX.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned)
- BHT_ENTRIES, 16, number of 2-bit counters; power of 2, ≥2; index = pc[log2(BHT_ENTRIES)+1:2]

Ports:
- clk_i  in  1  single clock, rising edge
- n_rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  6  CTRL stall vector; bit 0 = PC stage; 1 = STOP
- flush_i  in  1  CTRL flush (trap/exception)
- flush_pc_i  in  32  fetch target on flush
- branch_redirect_i  in  1  EX mispredict correction
- branch_redirect_pc_i  in  32  corrected fetch target
- bht_update_i  in  1  EX resolved a conditional branch this cycle
- bht_update_pc_i  in  32  PC of that branch
- bht_update_taken_i  in  1  resolved direction
- ins_i  in  32  ROM data for ins_addr_o, same cycle (combinational ROM)
- ins_ce_o  out  1  ROM chip enable
- ins_addr_o  out  32  ROM address (= pc_o)
- pc_o  out  32  current fetch PC, registered
- next_pc_o  out  32  predicted next PC
- next_taken_o  out  1  prediction departs from pc_o+4
- branch_slot_end_o  out  1  fetched word is a predicted-taken control transfer (last word of sequential run)

## Operation
- Two states. RESET_WAIT is entered on reset: ins_ce_o=0, prediction outputs forced to the reset values. RUN: ins_ce_o=1. RESET_WAIT→RUN on the first clock edge after n_rst_i deasserts; never returns except via reset.
- Reset values: pc_o=RESET_PC, ins_addr_o=RESET_PC, ins_ce_o=0, next_pc_o=RESET_PC+4, next_taken_o=0, branch_slot_end_o=0. All BHT counters are 2'b01 (weakly not-taken).
- Prediction is combinational in RUN, from pc_o and ins_i:
  - opcode 7'b1101111 (JAL): target = pc_o + sign-extended J-immediate; taken=1.
  - opcode 7'b1100011 (B-type): target = pc_o + sign-extended B-immediate. taken = counter[idx(pc_o)][1].
  - All other opcodes, including JALR: pc_o+4, taken=0.
  - next_pc_o = taken ? target : pc_o+4. branch_slot_end_o = next_taken_o.
- All adds are 32-bit and wrap modulo 2^32. Target bit 0 is forced to 0.
- PC update at each edge in RUN, first match wins:
  - branch_redirect_i → branch_redirect_pc_i
  - flush_i → flush_pc_i
  - stall_i[0]==1 → hold
  - otherwise → next_pc_o
- BHT update: when bht_update_i=1, counter[idx(bht_update_pc_i)] saturating-increments if taken, saturating-decrements if not taken. Bounds are 2'b00 and 2'b11.
  - The update applies regardless of stall, flush or redirect.
  - The update is also accepted in RESET_WAIT.
- Same-cycle update and lookup on the same index: prediction uses the pre-update value. The new value is visible the next cycle.
- Stall does not gate next_pc_o or next_taken_o. They keep tracking the held pc_o and the current ins_i.

## Timing
- pc_o, ins_ce_o and BHT are registered. next_pc_o, next_taken_o and branch_slot_end_o are combinational from pc_o, ins_i and BHT.
- Redirect/flush latency: asserted in cycle N → pc_o equals the new target in cycle N+1. The fetch in cycle N is discarded by IF/ID.
- Sequential fetch: one new PC per cycle when unstalled.
- Reset release: pc_o=RESET_PC fetched with ins_ce_o=1 from the first cycle after release.
- Mid-operation reset clears pc_o and all counters immediately (asynchronous).

## Test plan
- Reset, then release with NOPs in ROM → ins_ce_o 0 then 1; pc_o sequence 0,4,8,C; next_taken_o=0 throughout.
- At pc 0x10, JAL with imm=+0x20 → next_pc_o=0x30, next_taken_o=1, branch_slot_end_o=1; pc_o=0x30 next cycle.
- BEQ at 0x40, imm −8 → first fetch predicts 0x44 (counter 01). Apply bht_update taken ×1 → counter 10; re-fetch predicts 0x38. Update taken ×3 more → counter stays 11. Update not-taken ×1 → still predicts taken (10).
- stall_i[0]=1 for 3 cycles at pc 0x8 → pc_o holds 0x8; release → 0xC.
- Same cycle: branch_redirect_i=1 (pc 0x100), flush_i=1 (pc 0x200), stall_i[0]=1 → pc_o=0x100 next cycle.
- Wrap: pc_o=0xFFFF_FFFC with a NOP → next_pc_o=0x0000_0000. Assert n_rst_i=0 mid-run → pc_o=RESET_PC and ins_ce_o=0 without waiting for a clock edge.

Source files
------------

// File: rtl/ifu_pc_gen.sv
// Fetch-stage PC generator: holds the fetch PC, drives the instruction ROM and
// predicts the next PC (static JAL, 2-bit counter BHT for conditional branches).
module ifu_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_redirect_i,
  input  logic [31:0] branch_redirect_pc_i,
  input  logic        bht_update_i,
  input  logic [31:0] bht_update_pc_i,
  input  logic        bht_update_taken_i,
  input  logic [31:0] ins_i,
  output logic        ins_ce_o,
  output logic [31:0] ins_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] next_pc_o,
  output logic        next_taken_o,
  output logic        branch_slot_end_o
);

  localparam int IDXW = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {RESET_WAIT, RUN} state_t;

  state_t      r_state;
  logic        r_insCe;
  logic [31:0] r_pc;
  logic [1:0]  r_bht [BHT_ENTRIES];

  logic [IDXW-1:0] w_lookupIdx;
  logic [IDXW-1:0] w_updateIdx;
  logic [1:0]      w_counter;
  logic [31:0]     w_jImm;
  logic [31:0]     w_bImm;
  logic [31:0]     w_target;
  logic [31:0]     w_nextPc;
  logic            w_taken;
  logic            w_unused;

  assign w_lookupIdx = r_pc[IDXW+1:2];
  assign w_updateIdx = bht_update_pc_i[IDXW+1:2];
  assign w_counter   = r_bht[w_lookupIdx];
  assign w_jImm = {{12{ins_i[31]}}, ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
  assign w_bImm = {{20{ins_i[31]}}, ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
  assign w_unused = ^{stall_i[5:1], bht_update_pc_i[31:IDXW+2], bht_update_pc_i[1:0]};

  // Prediction reads the counter as registered, so a same-cycle update is seen next cycle.
  always_comb begin
    w_target = r_pc;
    w_taken  = 1'b0;
    w_nextPc = r_pc + 32'd4;
    if (r_state == RUN) begin
      if (ins_i[6:0] == OP_JAL) begin
        w_target = (r_pc + w_jImm) & ~32'd1;
        w_taken  = 1'b1;
      end else if (ins_i[6:0] == OP_BRANCH) begin
        w_target = (r_pc + w_bImm) & ~32'd1;
        w_taken  = w_counter[1];
      end
      if (w_taken) w_nextPc = w_target;
    end else begin
      w_nextPc = RESET_PC + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state <= RESET_WAIT;
      r_insCe <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        RESET_WAIT: begin
          r_state <= RUN;
          r_insCe <= 1'b1;
        end
        RUN: begin
          if (branch_redirect_i)  r_pc <= branch_redirect_pc_i;
          else if (flush_i)       r_pc <= flush_pc_i;
          else if (!stall_i[0])   r_pc <= w_nextPc;
        end
        default: begin
          r_state <= RESET_WAIT;
          r_insCe <= 1'b0;
        end
      endcase
    end
  end

  // Counter training is independent of state, stall, flush and redirect.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else if (bht_update_i) begin
      if (bht_update_taken_i && r_bht[w_updateIdx] != 2'b11)
        r_bht[w_updateIdx] <= r_bht[w_updateIdx] + 2'b01;
      else if (!bht_update_taken_i && r_bht[w_updateIdx] != 2'b00)
        r_bht[w_updateIdx] <= r_bht[w_updateIdx] - 2'b01;
    end
  end

  assign ins_ce_o          = r_insCe;
  assign ins_addr_o        = r_pc;
  assign pc_o              = r_pc;
  assign next_pc_o         = w_nextPc;
  assign next_taken_o      = w_taken;
  assign branch_slot_end_o = w_taken;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Bench for ifu_pc_gen: directed vector table, hand sequences for BHT training,
// wrap and async reset, then random traffic checked against a behavioural model.
module tb_ifu_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JALR     = 32'h0000_8067;
  localparam logic [31:0] JAL_P20  = 32'h0200_006F;
  localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;

  typedef struct {
    logic        stall, flush, redir, bhtUpd, bhtTaken;
    logic [31:0] flushPc, redirPc, bhtPc, ins;
    bit          useExp;
    logic [31:0] expPc, expNext;
    logic        expTaken, expCe;
  } vec_t;

  logic        clk, nRst;
  logic [5:0]  stall;
  logic        flush, redir, bhtUpd, bhtTaken;
  logic [31:0] flushPc, redirPc, bhtPc, ins;
  logic        insCe, nextTaken, slotEnd;
  logic [31:0] insAddr, pc, nextPc;

  int nVectors = 0;
  int nMiscompares = 0;
  int cycle = 0;

  logic [31:0] mPc;
  int          mBht [16];
  bit          mRun;

  ifu_pc_gen #(.RESET_PC(RESET_PC), .BHT_ENTRIES(16)) dut (
    .clk_i(clk), .n_rst_i(nRst), .stall_i(stall), .flush_i(flush),
    .flush_pc_i(flushPc), .branch_redirect_i(redir), .branch_redirect_pc_i(redirPc),
    .bht_update_i(bhtUpd), .bht_update_pc_i(bhtPc), .bht_update_taken_i(bhtTaken),
    .ins_i(ins), .ins_ce_o(insCe), .ins_addr_o(insAddr), .pc_o(pc),
    .next_pc_o(nextPc), .next_taken_o(nextTaken), .branch_slot_end_o(slotEnd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic s, logic f, logic r, logic [31:0] fpc, logic [31:0] rpc,
                              logic [31:0] i, logic [31:0] ePc, logic [31:0] eNext, logic eTk);
    vec_t v;
    v.stall = s; v.flush = f; v.redir = r; v.flushPc = fpc; v.redirPc = rpc; v.ins = i;
    v.bhtUpd = 1'b0; v.bhtTaken = 1'b0; v.bhtPc = 32'h0;
    v.useExp = 1'b1; v.expPc = ePc; v.expNext = eNext; v.expTaken = eTk; v.expCe = 1'b1;
    return v;
  endfunction

  function automatic vec_t withBht(vec_t vin, logic [31:0] upc, logic tk);
    vec_t v = vin;
    v.bhtUpd = 1'b1; v.bhtPc = upc; v.bhtTaken = tk;
    return v;
  endfunction

  // Reference prediction straight from the opcode rules, using signed integer arithmetic.
  function automatic void modelPredict(input logic [31:0] p, input logic [31:0] w,
                                       output logic [31:0] np, output logic tk);
    longint imm = 0;
    np = p + 32'd4;
    tk = 1'b0;
    if (!mRun) begin
      np = RESET_PC + 32'd4;
      return;
    end
    if (w[6:0] == 7'b1101111) begin
      imm = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0});
      if (w[31]) imm = imm - (longint'(1) << 21);
      tk = 1'b1;
    end else if (w[6:0] == 7'b1100011) begin
      imm = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0});
      if (w[31]) imm = imm - (longint'(1) << 13);
      tk = (mBht[int'(p >> 2) % 16] >= 2);
    end
    if (tk) np = 32'(longint'(p) + imm) & ~32'd1;
  endfunction

  task automatic modelReset();
    mPc = RESET_PC;
    mRun = 1'b0;
    for (int i = 0; i < 16; i++) mBht[i] = 1;
  endtask

  task automatic modelClock(input vec_t v);
    logic [31:0] np;
    logic tk;
    int k;
    modelPredict(mPc, v.ins, np, tk);
    if (v.bhtUpd) begin
      k = int'(v.bhtPc >> 2) % 16;
      if (v.bhtTaken) mBht[k] = (mBht[k] < 3) ? mBht[k] + 1 : 3;
      else            mBht[k] = (mBht[k] > 0) ? mBht[k] - 1 : 0;
    end
    if (mRun) begin
      if (v.redir)       mPc = v.redirPc;
      else if (v.flush)  mPc = v.flushPc;
      else if (!v.stall) mPc = np;
    end
    mRun = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s @cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic checkAll(input logic [31:0] ePc, input logic [31:0] eNext,
                          input logic eTk, input logic eCe);
    checkOutput("pc_o", pc, ePc);
    checkOutput("ins_addr_o", insAddr, ePc);
    checkOutput("next_pc_o", nextPc, eNext);
    checkOutput("next_taken_o", 32'(nextTaken), 32'(eTk));
    checkOutput("branch_slot_end_o", 32'(slotEnd), 32'(eTk));
    checkOutput("ins_ce_o", 32'(insCe), 32'(eCe));
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] np;
    logic tk;
    @(negedge clk);
    stall    = {$urandom_range(0, 31) == 0 ? 5'h1F : 5'h00, v.stall};
    flush    = v.flush;    flushPc = v.flushPc;
    redir    = v.redir;    redirPc = v.redirPc;
    bhtUpd   = v.bhtUpd;   bhtPc   = v.bhtPc;   bhtTaken = v.bhtTaken;
    ins      = v.ins;
    #1;
    if (v.useExp) begin
      checkAll(v.expPc, v.expNext, v.expTaken, v.expCe);
    end else begin
      modelPredict(mPc, v.ins, np, tk);
      checkAll(mPc, np, tk, mRun);
    end
    @(posedge clk);
    modelClock(v);
    cycle++;
  endtask

  function automatic logic [31:0] randIns();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 4))
      0: return NOP;
      1: return {r[31:7], 7'b1101111};
      2: return {r[31:7], 7'b1100011};
      3: return JALR;
      default: return r;
    endcase
  endfunction

  vec_t vecs[$];
  vec_t v;

  initial begin
    nRst = 1'b0; stall = '0; flush = 1'b0; redir = 1'b0; bhtUpd = 1'b0;
    bhtTaken = 1'b0; flushPc = '0; redirPc = '0; bhtPc = '0; ins = NOP;
    modelReset();

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #2;
    checkAll(RESET_PC, RESET_PC + 32'd4, 1'b0, 1'b0);

    // Release; the RESET_WAIT cycle also trains counter idx 2 (pc 0x48) once.
    #1 nRst = 1'b1;
    v = withBht(mk(0, 0, 0, 0, 0, NOP, RESET_PC, RESET_PC + 32'd4, 0), 32'h48, 1'b1);
    v.expCe = 1'b0;
    applyStimulus(v);

    vecs.push_back(mk(0, 0, 0, 0, 0, NOP, 32'h00, 32'h04, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, NOP, 32'h04, 32'h08, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, NOP, 32'h08, 32'h0C, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, NOP, 32'h08, 32'h0C, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, NOP, 32'h08, 32'h0C, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, NOP, 32'h08, 32'h0C, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, NOP, 32'h0C, 32'h10, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, JAL_P20, 32'h10, 32'h30, 1));
    vecs.push_back(mk(1, 1, 1, 32'h200, 32'h100, NOP, 32'h30, 32'h34, 0));
    vecs.push_back(mk(1, 1, 0, 32'h200, 32'h0, NOP, 32'h100, 32'h104, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, NOP, 32'h200, 32'h204, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, JALR, 32'h204, 32'h208, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, BEQ_M8, 32'h208, 32'h200, 1));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // BHT training at 0x40 while stalled: prediction lags the update by one cycle.
    applyStimulus(mk(0, 0, 1, 0, 32'h40, NOP, 32'h200, 32'h204, 0));
    applyStimulus(withBht(mk(1, 0, 0, 0, 0, BEQ_M8, 32'h40, 32'h44, 0), 32'h40, 1'b1));
    applyStimulus(withBht(mk(1, 0, 0, 0, 0, BEQ_M8, 32'h40, 32'h38, 1), 32'h40, 1'b1));
    applyStimulus(withBht(mk(1, 0, 0, 0, 0, BEQ_M8, 32'h40, 32'h38, 1), 32'h40, 1'b1));
    applyStimulus(withBht(mk(1, 0, 0, 0, 0, BEQ_M8, 32'h40, 32'h38, 1), 32'h40, 1'b1));
    applyStimulus(withBht(mk(1, 0, 0, 0, 0, BEQ_M8, 32'h40, 32'h38, 1), 32'h40, 1'b0));
    applyStimulus(mk(0, 0, 0, 0, 0, BEQ_M8, 32'h40, 32'h38, 1));

    // Wrap past the top of the address space.
    applyStimulus(mk(0, 0, 1, 0, 32'hFFFF_FFFC, NOP, 32'h38, 32'h3C, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, NOP, 32'hFFFF_FFFC, 32'h0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, NOP, 32'h0, 32'h4, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, NOP, 32'h4, 32'h8, 0));

    // Asynchronous mid-run reset, visible without a clock edge.
    @(negedge clk);
    #2 nRst = 1'b0;
    modelReset();
    #1;
    checkOutput("async pc_o", pc, RESET_PC);
    checkOutput("async ins_ce_o", 32'(insCe), 32'h0);
    @(posedge clk);
    #1 nRst = 1'b1;
    v = mk(0, 0, 0, 0, 0, NOP, RESET_PC, RESET_PC + 32'd4, 0);
    v.expCe = 1'b0;
    applyStimulus(v);
    applyStimulus(mk(0, 0, 1, 0, 32'h40, NOP, 32'h0, 32'h4, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, BEQ_M8, 32'h40, 32'h44, 0));

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      v.stall    = ($urandom_range(0, 3) == 0);
      v.flush    = ($urandom_range(0, 11) == 0);
      v.redir    = ($urandom_range(0, 11) == 0);
      v.flushPc  = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      v.redirPc  = 32'($urandom_range(0, 63)) * 4;
      v.bhtUpd   = ($urandom_range(0, 1) == 1);
      v.bhtPc    = ($urandom_range(0, 1) == 1) ? mPc : 32'($urandom_range(0, 31)) * 4;
      v.bhtTaken = ($urandom_range(0, 1) == 1);
      v.ins      = randIns();
      v.useExp   = 1'b0;
      applyStimulus(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
